// File: rtl/minmax_reduce_int.sv
// Streaming arg-min/arg-max reducer: folds a valid/ready stream of integers into
// its extreme value, first-occurrence index and saturating element count.
`timescale 1ns/1ps

module minmax_reduce_int #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_max,
    input  logic             cfg_signed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W-1:0] out_count,
    output logic             out_overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             mode_max_q, mode_max_d;
    logic             mode_signed_q, mode_signed_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] out_value_q, out_value_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [IDX_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             res_accept;
    logic [WIDTH-1:0] key_in;
    logic [WIDTH-1:0] key_best;
    logic             better;

    // No bypass: DONE always blocks input, even in the cycle the result is taken.
    assign in_ready   = rst_n && (state_q != S_DONE);
    assign out_valid  = (state_q == S_DONE);
    assign accept     = in_valid && in_ready;
    assign res_accept = out_valid && out_ready;

    assign out_value    = out_value_q;
    assign out_index    = out_index_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_ovf_q;

    // Flipping the MSB maps two's-complement order onto unsigned order.
    always_comb begin
        key_in   = in_data ^ {mode_signed_q, {(WIDTH-1){1'b0}}};
        key_best = best_q  ^ {mode_signed_q, {(WIDTH-1){1'b0}}};
        if (mode_max_q) begin
            better = (key_in > key_best);
        end else begin
            better = (key_in < key_best);
        end
    end

    always_comb begin
        state_d       = state_q;
        mode_max_d    = mode_max_q;
        mode_signed_d = mode_signed_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        out_value_d   = out_value_q;
        out_index_d   = out_index_q;
        out_count_d   = out_count_q;
        out_ovf_d     = out_ovf_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mode_max_d    = cfg_max;
                    mode_signed_d = cfg_signed;
                    best_d        = in_data;
                    best_idx_d    = '0;
                    cnt_d         = IDX_W'(1);
                    ovf_d         = 1'b0;
                    state_d       = in_last ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    // cnt_q is the index of this beat; it saturates, so late winners record CNT_MAX.
                    if (better) begin
                        best_d     = in_data;
                        best_idx_d = cnt_q;
                    end
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                    if (in_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (res_accept) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result registers load only on the last beat, so they hold across handshakes.
        if (accept && in_last) begin
            out_value_d = best_d;
            out_index_d = best_idx_d;
            out_count_d = cnt_d;
            out_ovf_d   = ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mode_max_q    <= 1'b0;
            mode_signed_q <= 1'b0;
            best_q        <= '0;
            best_idx_q    <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            out_value_q   <= '0;
            out_index_q   <= '0;
            out_count_q   <= '0;
            out_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_max_q    <= mode_max_d;
            mode_signed_q <= mode_signed_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            out_value_q   <= out_value_d;
            out_index_q   <= out_index_d;
            out_count_q   <= out_count_d;
            out_ovf_q     <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_minmax_reduce_int.sv
// Directed bench for minmax_reduce_int: a 32/16 instance for the main modes and
// a 32/4 instance for count saturation and overflow.
`timescale 1ns/1ps

module tb_minmax_reduce_int;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        cfg_max, cfg_signed, in_valid, in_last, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_overflow;
    logic [31:0] out_value;
    logic [15:0] out_index, out_count;

    logic        b_cfg_max, b_cfg_signed, b_in_valid, b_in_last, b_out_ready;
    logic [31:0] b_in_data;
    logic        b_in_ready, b_out_valid, b_out_overflow;
    logic [31:0] b_out_value;
    logic [3:0]  b_out_index, b_out_count;

    int checks   = 0;
    int failures = 0;

    minmax_reduce_int #(.WIDTH(32), .IDX_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cfg_max(cfg_max), .cfg_signed(cfg_signed),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_value(out_value), .out_index(out_index),
        .out_count(out_count), .out_overflow(out_overflow)
    );

    minmax_reduce_int #(.WIDTH(32), .IDX_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cfg_max(b_cfg_max), .cfg_signed(b_cfg_signed),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_value(b_out_value), .out_index(b_out_index),
        .out_count(b_out_count), .out_overflow(b_out_overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic beat(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: in_ready=0 expected=1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic result(input string tag, input logic [31:0] v, input logic [15:0] i,
                          input logic [15:0] c, input logic o);
        $display("result %s: value=%h index=%0d count=%0d ovf=%b valid=%b",
                 tag, out_value, out_index, out_count, out_overflow, out_valid);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_value"}, out_value, v);
        chk({tag, "_index"}, out_index, i);
        chk({tag, "_count"}, out_count, c);
        chk({tag, "_ovf"}, out_overflow, o);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop"}, out_valid, 0);
    endtask

    task automatic b_beat(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_last  = last;
        while (!b_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!b_in_ready) begin
            checks++;
            failures++;
            $display("FAIL b_beat_timeout: in_ready=0 expected=1");
        end
        @(negedge clk);
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
    endtask

    task automatic b_result(input string tag, input logic [31:0] v, input logic [3:0] i,
                            input logic [3:0] c, input logic o);
        $display("result %s: value=%h index=%0d count=%0d ovf=%b valid=%b",
                 tag, b_out_value, b_out_index, b_out_count, b_out_overflow, b_out_valid);
        chk({tag, "_valid"}, b_out_valid, 1);
        chk({tag, "_value"}, b_out_value, v);
        chk({tag, "_index"}, b_out_index, i);
        chk({tag, "_count"}, b_out_count, c);
        chk({tag, "_ovf"}, b_out_overflow, o);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        chk({tag, "_drop"}, b_out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cfg_max = 1'b0; cfg_signed = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        out_ready = 1'b0;
        b_cfg_max = 1'b1; b_cfg_signed = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
        b_in_last = 1'b0; b_out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_value", out_value, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_ovf", out_overflow, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        @(negedge clk);

        // Signed min, tie keeps first -3
        cfg_max = 1'b0; cfg_signed = 1'b1;
        beat(32'd5, 1'b0);
        beat(32'hFFFF_FFFD, 1'b0);
        beat(32'd7, 1'b0);
        beat(32'hFFFF_FFFD, 1'b1);
        result("smin", 32'hFFFF_FFFD, 16'd1, 16'd4, 1'b0);

        // Same data under three modes
        cfg_max = 1'b1; cfg_signed = 1'b0;
        beat(32'h8000_0000, 1'b0);
        beat(32'h0000_0001, 1'b1);
        result("umax", 32'h8000_0000, 16'd0, 16'd2, 1'b0);
        cfg_max = 1'b1; cfg_signed = 1'b1;
        beat(32'h8000_0000, 1'b0);
        beat(32'h0000_0001, 1'b1);
        result("smax", 32'h0000_0001, 16'd1, 16'd2, 1'b0);
        cfg_max = 1'b0; cfg_signed = 1'b1;
        beat(32'h8000_0000, 1'b0);
        beat(32'h0000_0001, 1'b1);
        result("smin2", 32'h8000_0000, 16'd0, 16'd2, 1'b0);

        // Single-beat stream
        cfg_max = 1'b1; cfg_signed = 1'b0;
        beat(32'h0000_1234, 1'b1);
        result("single", 32'h0000_1234, 16'd0, 16'd1, 1'b0);

        // cfg changes mid-stream are ignored: stays unsigned min
        cfg_max = 1'b0; cfg_signed = 1'b0;
        beat(32'd10, 1'b0);
        cfg_max = 1'b1; cfg_signed = 1'b1;
        beat(32'd20, 1'b0);
        beat(32'hFFFF_FFFF, 1'b0);
        beat(32'd3, 1'b1);
        result("cfg_ignored", 32'd3, 16'd3, 16'd4, 1'b0);

        // Backpressure in DONE with a pending input beat
        cfg_max = 1'b0; cfg_signed = 1'b0;
        beat(32'd7, 1'b0);
        beat(32'd7, 1'b1);
        in_valid = 1'b1; in_data = 32'h55; in_last = 1'b1; cfg_max = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_value", out_value, 32'd7);
            chk("bp_out_index", out_index, 0);
            chk("bp_out_count", out_count, 2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_drop", out_valid, 0);
        chk("bp_ready_after", in_ready, 1);
        chk("bp_value_hold", out_value, 32'd7);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        result("bp_next", 32'h55, 16'd0, 16'd1, 1'b0);

        // Count saturation on the narrow instance: exactly 15 beats, no overflow
        b_cfg_max = 1'b1; b_cfg_signed = 1'b0;
        for (int k = 0; k < 15; k++) begin
            b_beat(32'(k), (k == 14));
        end
        b_result("sat15", 32'd14, 4'd14, 4'd15, 1'b0);
        // 20 beats, max 99 at position 17
        for (int k = 0; k < 20; k++) begin
            b_beat((k == 17) ? 32'd99 : 32'(k), (k == 19));
        end
        b_result("ovf20", 32'd99, 4'd15, 4'd15, 1'b1);

        // Reset in the middle of a stream
        cfg_max = 1'b1; cfg_signed = 1'b0;
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        beat(32'd3, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_value", out_value, 0);
        chk("mrst_out_count", out_count, 0);
        chk("mrst_b_count", b_out_count, 0);
        chk("mrst_b_ovf", b_out_overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cfg_max = 1'b0; cfg_signed = 1'b0;
        beat(32'd9, 1'b0);
        beat(32'd2, 1'b1);
        result("post_rst", 32'd2, 16'd1, 16'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
